// File: rtl/pulse_width_meter.sv
// pulse_width_meter
//   Measures the length of each constant-level interval on a filtered bit,
//   counted in sample strobes (en), and queues one {level, count, saturated}
//   record per completed interval in a small first-word-fall-through FIFO.
//
//   Parameters
//     CNT_WIDTH  width of the interval counter / outCount
//     FIFO_LOG2  log2 of the record FIFO depth (>= 1)
//
//   Ports
//     clk       in   system clock
//     rst_n     in   asynchronous active-low reset
//     en        in   sample strobe shared with the upstream filter
//     bitIn     in   filtered bit
//     outReady  in   consumer accepts the head record
//     clrOvf    in   clears the sticky overflow flag
//     outValid  out  head record present
//     outLevel  out  level of the measured interval
//     outCount  out  number of strobes observed at that level
//     outSat    out  outCount saturated
//     overflow  out  sticky: a record was dropped on a full FIFO

// Record FIFO, first-word-fall-through. A push into a full FIFO is accepted
// only if a pop happens on the same edge; otherwise it is reported as a drop.
module pwm_rec_fifo #(
  parameter int W         = 8,
  parameter int FIFO_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop_req,
  output logic         valid,
  output logic [W-1:0] rdata,
  output logic         drop
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] FILL_MAX = (FIFO_LOG2+1)'(DEPTH);

  logic [W-1:0]         mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_LOG2:0]   fill;
  logic                 full, pop, wr_en;

  assign valid = (fill != '0);
  assign full  = (fill == FILL_MAX);
  assign pop   = valid && pop_req;
  // the same-edge pop frees the slot the push needs
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;
  assign rdata = mem[rd_ptr];

  // storage is not reset; valid gates everything read from it
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end
endmodule

module pulse_width_meter #(
  parameter int CNT_WIDTH = 16,
  parameter int FIFO_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 bitIn,
  input  logic                 outReady,
  input  logic                 clrOvf,
  output logic                 outValid,
  output logic                 outLevel,
  output logic [CNT_WIDTH-1:0] outCount,
  output logic                 outSat,
  output logic                 overflow
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam int REC_W = CNT_WIDTH + 2;

  typedef struct packed {
    logic                 level;
    logic [CNT_WIDTH-1:0] count;
    logic                 sat;
  } rec_t;

  typedef enum logic {SYNC = 1'b0, MEASURE = 1'b1} state_t;

  state_t               state, state_nxt;
  logic                 prev_bit;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 sat;
  logic                 edge_det;
  logic                 push, cnt_restart, cnt_inc;
  logic                 drop, head_vld;
  rec_t                 wrec, head;

  assign edge_det = en && (bitIn != prev_bit);

  // ---- FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SYNC;
    else        state <= state_nxt;
  end

  // ---- FSM: next state (the first edge only arms measurement)
  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:    if (edge_det) state_nxt = MEASURE;
      MEASURE: state_nxt = MEASURE;
      default: state_nxt = SYNC;
    endcase
  end

  // ---- FSM: outputs
  // The interval before the first edge is partial, so SYNC restarts the
  // counter on that edge without emitting a record.
  always_comb begin
    push        = 1'b0;
    cnt_restart = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      SYNC: cnt_restart = edge_det;
      MEASURE: begin
        push        = edge_det;
        cnt_restart = edge_det;
        cnt_inc     = en && !edge_det;
      end
      default: ;
    endcase
  end

  // ---- interval counter; the new-level sample is the first of the next
  // interval, hence the restart value of 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_bit <= 1'b0;
      cnt      <= '0;
      sat      <= 1'b0;
    end else begin
      if (en) prev_bit <= bitIn;
      if (cnt_restart) begin
        cnt <= CNT_WIDTH'(1);
        sat <= 1'b0;
      end else if (cnt_inc) begin
        if (cnt == CNT_MAX) sat <= 1'b1;
        else                cnt <= cnt + 1'b1;
      end
    end
  end

  assign wrec = '{level: prev_bit, count: cnt, sat: sat};

  pwm_rec_fifo #(.W(REC_W), .FIFO_LOG2(FIFO_LOG2)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wdata   (wrec),
    .pop_req (outReady),
    .valid   (head_vld),
    .rdata   (head),
    .drop    (drop)
  );

  // set beats clear when both land on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      overflow <= 1'b0;
    else if (drop)   overflow <= 1'b1;
    else if (clrOvf) overflow <= 1'b0;
  end

  // fields read as zero whenever no record is present, including in reset
  assign outValid = head_vld;
  assign outLevel = head_vld & head.level;
  assign outCount = head_vld ? head.count : '0;
  assign outSat   = head_vld & head.sat;
endmodule

// File: doc/pulse_width_meter.md
# pulse_width_meter

Measures the duration of each constant-level interval on the filtered bit from the RC hysteresis filter, in units of sample-enable strobes. Sits directly downstream of the filter, sharing its `clk` and `en`. Each completed interval is queued in a small FIFO as a {level, count, saturated} record. Records are read out over a valid/ready handshake by decode logic such as a bit-period estimator or a protocol front-end.

## Interface
Parameters:
- `CNT_WIDTH`, 16: width of the interval counter and of `outCount`.
- `FIFO_LOG2`, 2: log2 of the record FIFO depth (default 4 records).

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `en`  in  1: sample strobe, same strobe that drives the filter.
- `bitIn`  in  1: filtered bit (filter `bitOut`).
- `outReady`  in  1: consumer accepts the head record.
- `clrOvf`  in  1: clears the sticky `overflow` flag.
- `outValid`  out  1: head record present.
- `outLevel`  out  1: level of the measured interval.
- `outCount`  out  CNT_WIDTH: number of `en` samples observed at that level.
- `outSat`  out  1: `outCount` saturated.
- `overflow`  out  1: sticky; a record was dropped because the FIFO was full.

## Operation
- `bitIn` is only looked at on cycles with `en`=1. `prevBit` updates only then.
- Edge = `en` && (`bitIn` != `prevBit`).
- Two-state FSM:
  - SYNC (reset state): waits for the first edge. The interval before it is partial and is discarded. On the edge: go to MEASURE, `cnt`=1, no push.
  - MEASURE, `en` with no edge: `cnt` += 1, saturating at 2^CNT_WIDTH−1. The `sat` flag is set when an increment is attempted at max.
  - MEASURE, edge: push {`prevBit`, `cnt`, `sat`}. Then `cnt`=1 and `sat`=0. The new-level sample counts as the first sample of the next interval.
  - `en`=0: `cnt`, `sat`, `prevBit` and FSM state hold.
- FIFO depth is 2^FIFO_LOG2. Push occurs on an edge in MEASURE. Pop occurs when `outValid` && `outReady`.
  - Full, push, no pop: the record is dropped and `overflow` is set. FIFO contents are unchanged.
  - Full, push and pop in the same cycle: both are performed and nothing is dropped.
  - Empty: pop is impossible because `outValid`=0.
- Output is first-word-fall-through. `outLevel`/`outCount`/`outSat` present the head record whenever `outValid`=1, and are held stable while `outValid` && !`outReady`.
- `overflow` stays set until `clrOvf`=1. If a set and `clrOvf` happen in the same cycle, set wins.
- Reset asserted (any time, including mid-interval or with records queued):
  - FSM returns to SYNC; `prevBit`=0, `cnt`=0, `sat`=0; FIFO is emptied.
  - Outputs: `outValid`=0, `outLevel`=0, `outCount`=0, `outSat`=0, `overflow`=0.
  - Outputs take these values immediately (asynchronous) and hold until the first clock after `rst_n` rises.

## Timing
- An edge sampled at rising clock N with the FIFO empty gives `outValid`=1 after clock N, i.e. visible in cycle N+1. Latency is 1 cycle.
- Pop at clock M: the next record (if any) appears after clock M, with no bubble.
- Fill level, `overflow`, `cnt` and FSM state all update on the same edge as the push/pop.
- Throughput is one push and one pop per cycle.
- The minimum interval is 1 sample, which happens when `en` is continuous and the level toggles every strobe.

## Test plan
- Reset: hold `rst_n`=0 with `bitIn`=1, `en`=1 → all outputs 0. Assert `rst_n`=0 mid-interval with 2 records queued → `outValid` drops without a clock edge; after release, the first edge produces no record.
- Basic, `en`=1 continuous, `outReady`=1: `bitIn` 0 for 5 cycles, then 1 for 10, then 0.
  - No record for the initial partial interval.
  - Exactly one record {1, 10, 0}, with `outValid` high one cycle after the falling sample.
- Strobed, `en` high 1 cycle in 4: `bitIn` high for 7 strobes (28 clocks) between edges → record {1, 7, 0}. Toggling `bitIn` while `en`=0 has no effect.
- Saturation with CNT_WIDTH=4: hold level 0 for 20 strobes, then rise → record {0, 15, 1}. The next interval of 3 strobes → {1, 3, 0}.
- Backpressure with `outReady`=0 and 5 completed intervals of lengths 2, 3, 4, 5, 6:
  - The first 4 are stored and the 5th is dropped, with `overflow`=1.
  - Raising `outReady` drains 2, 3, 4, 5 in order.
  - `clrOvf` clears `overflow`.
  - Repeat with a pop in the same cycle as the 5th push → no drop and `overflow` stays 0.
